// File: rtl/battleship_pkg.sv
// Shared definitions for the 5x5 battleship game: cell codes, controller
// states and a saturating hit-counter helper.
package battleship_pkg;

    localparam int N_DEFAULT = 5;

    localparam logic [1:0] AGUA          = 2'b00;
    localparam logic [1:0] BARCO         = 2'b01;
    localparam logic [1:0] TIRO_FALLADO  = 2'b10;
    localparam logic [1:0] TIRO_ACERTADO = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PLAYER_WAIT,
        PLAYER_EVAL,
        PC_SELECT,
        GAME_OVER
    } state_t;

    // Counters stop at the win threshold so they can never wrap.
    function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
        return (v >= lim) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/control_turnos_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the PC shot generator.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/control_turnos.sv
// Turn controller: arbitrates the board read/write ports between the
// player's shots and the PC shooter, counts hits and declares the winner.
module control_turnos
    import battleship_pkg::*;
#(
    parameter int         N            = N_DEFAULT,
    parameter int         SHIPS_TO_WIN = 3,
    parameter int         TURN_TIMEOUT = 50_000_000,
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    parameter int         SCAN_AFTER   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       shot_valid,
    input  logic [2:0] shot_row,
    input  logic [2:0] shot_col,
    output logic       shot_ready,
    output logic       rd_board,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic       wr_board,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [1:0] wr_data,
    output logic       clear_req,
    output logic       player_turn,
    output logic       repeat_shot,
    output logic       bad_coord,
    output logic [2:0] player_hits,
    output logic [2:0] pc_hits,
    output logic       game_over,
    output logic       player_won
);

    localparam int TW = $clog2(TURN_TIMEOUT + 1);
    localparam int SW = (SCAN_AFTER > 0) ? $clog2(SCAN_AFTER + 1) : 1;
    localparam logic [2:0]    NC        = 3'(N);
    localparam logic [2:0]    WIN       = 3'(SHIPS_TO_WIN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TURN_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TURN_TIMEOUT);
    localparam logic [SW-1:0] SCAN_LIM  = SW'(SCAN_AFTER);

    state_t          state, state_nxt;
    logic [2:0]      tgt_row, tgt_col;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   rej_cnt;
    logic [2:0]      scan_row, scan_col;
    logic [7:0]      lfsr_q;
    logic            unused_lfsr;

    logic            new_game, take_shot, player_hit, pc_hit, pc_done, pc_reject;
    logic            scanning, cand_ok;
    logic [2:0]      cand_row, cand_col;
    logic [2:0]      player_hits_inc, pc_hits_inc;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign unused_lfsr     = ^lfsr_q[7:6];
    assign scanning        = (rej_cnt == SCAN_LIM);
    assign cand_row        = scanning ? scan_row : lfsr_q[2:0];
    assign cand_col        = scanning ? scan_col : lfsr_q[5:3];
    assign player_hits_inc = sat_inc(player_hits, WIN);
    assign pc_hits_inc     = sat_inc(pc_hits, WIN);
    assign game_over       = (state == GAME_OVER);

    // Out-of-range candidates are rejected regardless of what the board returns.
    assign cand_ok = (cand_row < NC) && (cand_col < NC) && !rd_data[1];

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        shot_ready  = 1'b0;
        player_turn = 1'b0;
        rd_board    = 1'b0;
        rd_row      = 3'd0;
        rd_col      = 3'd0;
        wr_en       = 1'b0;
        wr_board    = 1'b0;
        wr_row      = 3'd0;
        wr_col      = 3'd0;
        wr_data     = TIRO_FALLADO;
        clear_req   = 1'b0;
        repeat_shot = 1'b0;
        bad_coord   = 1'b0;
        new_game    = 1'b0;
        take_shot   = 1'b0;
        player_hit  = 1'b0;
        pc_hit      = 1'b0;
        pc_done     = 1'b0;
        pc_reject   = 1'b0;

        // Strobes are suppressed in the reset cycle so an abort never writes.
        if (!rst) begin
            case (state)
                IDLE, GAME_OVER: begin
                    if (start) begin
                        clear_req = 1'b1;
                        new_game  = 1'b1;
                        state_nxt = PLAYER_WAIT;
                    end
                end

                PLAYER_WAIT: begin
                    shot_ready  = 1'b1;
                    player_turn = 1'b1;
                    if (shot_valid && (shot_row >= NC || shot_col >= NC)) begin
                        bad_coord = 1'b1;
                    end else if (shot_valid) begin
                        take_shot = 1'b1;
                        state_nxt = PLAYER_EVAL;
                    end
                    if (!take_shot && timer >= TMO_LAST) begin
                        state_nxt = PC_SELECT;
                    end
                end

                PLAYER_EVAL: begin
                    player_turn = 1'b1;
                    rd_board    = 1'b1;
                    rd_row      = tgt_row;
                    rd_col      = tgt_col;
                    if (rd_data[1]) begin
                        repeat_shot = 1'b1;
                        state_nxt   = PLAYER_WAIT;
                    end else begin
                        wr_en     = 1'b1;
                        wr_board  = 1'b1;
                        wr_row    = tgt_row;
                        wr_col    = tgt_col;
                        state_nxt = PC_SELECT;
                        if (rd_data == BARCO) begin
                            wr_data    = TIRO_ACERTADO;
                            player_hit = 1'b1;
                            if (player_hits_inc == WIN) begin
                                state_nxt = GAME_OVER;
                            end
                        end
                    end
                end

                PC_SELECT: begin
                    rd_board = 1'b0;
                    rd_row   = cand_row;
                    rd_col   = cand_col;
                    if (cand_ok) begin
                        wr_en     = 1'b1;
                        wr_row    = cand_row;
                        wr_col    = cand_col;
                        pc_done   = 1'b1;
                        state_nxt = PLAYER_WAIT;
                        if (rd_data == BARCO) begin
                            wr_data = TIRO_ACERTADO;
                            pc_hit  = 1'b1;
                            if (pc_hits_inc == WIN) begin
                                state_nxt = GAME_OVER;
                            end
                        end
                    end else begin
                        pc_reject = 1'b1;
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: only controller registers are reset here; board contents live in
    // external storage and are cleared through clear_req, never by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tgt_row     <= 3'd0;
            tgt_col     <= 3'd0;
            timer       <= '0;
            rej_cnt     <= '0;
            scan_row    <= 3'd0;
            scan_col    <= 3'd0;
            player_hits <= 3'd0;
            pc_hits     <= 3'd0;
            player_won  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (new_game || pc_done) begin
                timer <= '0;
            end else if (state == PLAYER_WAIT && timer != TMO_MAX) begin
                timer <= timer + 1'b1;
            end

            if (take_shot) begin
                tgt_row <= shot_row;
                tgt_col <= shot_col;
            end

            if (new_game) begin
                player_hits <= 3'd0;
                pc_hits     <= 3'd0;
                player_won  <= 1'b0;
            end else begin
                if (player_hit) begin
                    player_hits <= player_hits_inc;
                    if (player_hits_inc == WIN) begin
                        player_won <= 1'b1;
                    end
                end
                if (pc_hit) begin
                    pc_hits <= pc_hits_inc;
                end
            end

            // Random attempts first; once exhausted, walk the board row-major.
            if (state != PC_SELECT) begin
                rej_cnt  <= '0;
                scan_row <= 3'd0;
                scan_col <= 3'd0;
            end else if (pc_reject) begin
                if (!scanning) begin
                    rej_cnt <= rej_cnt + 1'b1;
                end else if (scan_col == NC - 3'd1) begin
                    scan_col <= 3'd0;
                    scan_row <= (scan_row == NC - 3'd1) ? 3'd0 : scan_row + 3'd1;
                end else begin
                    scan_col <= scan_col + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_control_turnos.sv
// Self-checking bench for control_turnos with a behavioural two-board store.
module tb_control_turnos;
    import battleship_pkg::*;

    localparam int TT  = 10;
    localparam int SA  = 32;
    localparam int WIN = 3;

    logic       clk, rst, start, shot_valid;
    logic [2:0] shot_row, shot_col;
    logic       shot_ready, rd_board, wr_en, wr_board, clear_req;
    logic [2:0] rd_row, rd_col, wr_row, wr_col;
    logic [1:0] rd_data, wr_data;
    logic       player_turn, repeat_shot, bad_coord, game_over, player_won;
    logic [2:0] player_hits, pc_hits;

    control_turnos #(
        .N(5), .SHIPS_TO_WIN(WIN), .TURN_TIMEOUT(TT), .LFSR_SEED(8'hA5), .SCAN_AFTER(SA)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .shot_valid(shot_valid), .shot_row(shot_row), .shot_col(shot_col),
        .shot_ready(shot_ready),
        .rd_board(rd_board), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .wr_en(wr_en), .wr_board(wr_board), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .clear_req(clear_req), .player_turn(player_turn),
        .repeat_shot(repeat_shot), .bad_coord(bad_coord),
        .player_hits(player_hits), .pc_hits(pc_hits),
        .game_over(game_over), .player_won(player_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board store: board[0] = player, board[1] = PC. pend_* are one-shot
    // overrides requested by the stimulus and applied on the next edge.
    logic [1:0] board    [2][5][5];
    logic       pend_en  [2][5][5];
    logic [1:0] pend_val [2][5][5];
    int         n_wr [2];
    int         n_clear;

    initial begin
        n_wr[0] = 0;
        n_wr[1] = 0;
        n_clear = 0;
    end

    always_comb begin
        rd_data = AGUA;
        if (rd_row < 3'd5 && rd_col < 3'd5)
            rd_data = board[int'(rd_board)][int'(rd_row)][int'(rd_col)];
    end

    always @(posedge clk) begin
        if (clear_req) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        board[b][r][c] <= AGUA;
            n_clear <= n_clear + 1;
        end else if (wr_en) begin
            if (wr_row < 3'd5 && wr_col < 3'd5)
                board[int'(wr_board)][int'(wr_row)][int'(wr_col)] <= wr_data;
            n_wr[int'(wr_board)] <= n_wr[int'(wr_board)] + 1;
        end
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    if (pend_en[b][r][c]) board[b][r][c] <= pend_val[b][r][c];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input int b, input int r, input int c, input logic [1:0] v);
        pend_en[b][r][c]  = 1'b1;
        pend_val[b][r][c] = v;
    endtask

    task automatic clear_pokes();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    pend_en[b][r][c] = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!shot_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", 32'(shot_ready), 32'd1);
    endtask

    // Counts player-turn cycles until the turn is forfeited.
    task automatic count_timeout(output int n);
        n = 0;
        while (player_turn && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for the PC write on the player board and checks where it lands.
    task automatic pc_expect(input string name, input logic [2:0] r, input logic [2:0] c,
                             input logic [1:0] d);
        int n = 0;
        while (!(wr_en && !wr_board) && n < SA + 25 + 2) begin
            @(negedge clk);
            n++;
        end
        check({name, "_seen"}, 32'(wr_en && !wr_board), 32'd1);
        check({name, "_row"},  32'(wr_row),  32'(r));
        check({name, "_col"},  32'(wr_col),  32'(c));
        check({name, "_data"}, 32'(wr_data), 32'(d));
    endtask

    typedef struct {
        logic [2:0] row;
        logic [2:0] col;
        logic       bad;
        logic       rep;
        logic       wr;
        logic [1:0] data;
        logic [2:0] hits;
        logic       over;
    } vec_t;

    vec_t vecs [7];
    int   wr0, wr1, tmo;

    initial begin
        // PC ships at (2,3), (0,0), (4,1); the player board stays all AGUA.
        vecs[0] = '{3'd2, 3'd3, 1'b0, 1'b0, 1'b1, TIRO_ACERTADO, 3'd1, 1'b0};
        vecs[1] = '{3'd5, 3'd0, 1'b1, 1'b0, 1'b0, AGUA,          3'd1, 1'b0};
        vecs[2] = '{3'd2, 3'd3, 1'b0, 1'b1, 1'b0, AGUA,          3'd1, 1'b0};
        vecs[3] = '{3'd1, 3'd1, 1'b0, 1'b0, 1'b1, TIRO_FALLADO,  3'd1, 1'b0};
        vecs[4] = '{3'd0, 3'd7, 1'b1, 1'b0, 1'b0, AGUA,          3'd1, 1'b0};
        vecs[5] = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b1, TIRO_ACERTADO, 3'd2, 1'b0};
        vecs[6] = '{3'd4, 3'd1, 1'b0, 1'b0, 1'b1, TIRO_ACERTADO, 3'd3, 1'b1};

        clear_pokes();
        rst = 1'b1; start = 1'b0; shot_valid = 1'b0; shot_row = 3'd0; shot_col = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_shot_ready",  32'(shot_ready),  32'd0);
        check("rst_wr_en",       32'(wr_en),       32'd0);
        check("rst_clear_req",   32'(clear_req),   32'd0);
        check("rst_player_turn", 32'(player_turn), 32'd0);
        check("rst_game_over",   32'(game_over),   32'd0);
        check("rst_hits",        32'({player_hits, pc_hits}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_clear", 32'(clear_req), 32'd0);

        // Game 1: start and place the PC ships in the clearing cycle.
        start = 1'b1;
        poke(1, 2, 3, BARCO); poke(1, 0, 0, BARCO); poke(1, 4, 1, BARCO);
        #1 check("start_clear_req", 32'(clear_req), 32'd1);
        @(negedge clk);
        start = 1'b0;
        clear_pokes();
        check("start_clear_once",  32'(clear_req),   32'd0);
        check("start_n_clear",     32'(n_clear),     32'd1);
        check("start_shot_ready",  32'(shot_ready),  32'd1);
        check("start_player_turn", 32'(player_turn), 32'd1);
        check("start_hits",        32'({player_hits, pc_hits}), 32'd0);

        for (int i = 0; i < 7; i++) begin
            wait_ready();
            wr0 = n_wr[0];
            wr1 = n_wr[1];
            shot_valid = 1'b1;
            shot_row   = vecs[i].row;
            shot_col   = vecs[i].col;
            #1 check($sformatf("v%0d_bad_coord", i), 32'(bad_coord), 32'(vecs[i].bad));
            @(negedge clk);
            shot_valid = 1'b0;
            check($sformatf("v%0d_repeat", i), 32'(repeat_shot), 32'(vecs[i].rep));
            check($sformatf("v%0d_wr_en", i),  32'(wr_en),       32'(vecs[i].wr));
            if (vecs[i].wr) begin
                check($sformatf("v%0d_wr_board", i), 32'(wr_board), 32'd1);
                check($sformatf("v%0d_wr_pos", i), 32'({wr_row, wr_col}),
                      32'({vecs[i].row, vecs[i].col}));
                check($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].data));
            end else begin
                check($sformatf("v%0d_turn_kept", i), 32'(player_turn), 32'd1);
            end
            if (vecs[i].over) begin
                @(negedge clk);
                check($sformatf("v%0d_game_over", i),  32'(game_over),  32'd1);
                check($sformatf("v%0d_player_won", i), 32'(player_won), 32'd1);
            end else begin
                wait_ready();
            end
            check($sformatf("v%0d_player_hits", i), 32'(player_hits), 32'(vecs[i].hits));
            check($sformatf("v%0d_pc_hits", i),     32'(pc_hits),     32'd0);
            check($sformatf("v%0d_pc_board_wr", i), 32'(n_wr[1] - wr1), 32'(vecs[i].wr));
            check($sformatf("v%0d_player_board_wr", i), 32'(n_wr[0] - wr0),
                  32'(vecs[i].wr && !vecs[i].over));
        end

        // Shots after the win are ignored.
        wr0 = n_wr[0];
        wr1 = n_wr[1];
        shot_valid = 1'b1; shot_row = 3'd3; shot_col = 3'd3;
        repeat (3) @(negedge clk);
        shot_valid = 1'b0;
        check("over_no_writes",  32'((n_wr[0] - wr0) + (n_wr[1] - wr1)), 32'd0);
        check("over_held",       32'({game_over, player_won, shot_ready}), 32'b110);
        check("over_hits_sat",   32'(player_hits), 32'd3);

        // Game 2: player board fully shot except (4,4); the PC must find it.
        start = 1'b1;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                poke(0, r, c, TIRO_FALLADO);
        poke(0, 4, 4, AGUA);
        @(negedge clk);
        start = 1'b0;
        clear_pokes();
        check("g2_restart_hits", 32'({player_hits, pc_hits, game_over}), 32'd0);
        wr1 = n_wr[1];
        count_timeout(tmo);
        check("g2_timeout_cycles", 32'(tmo), 32'(TT));
        check("g2_timeout_no_pc_write", 32'(n_wr[1] - wr1), 32'd0);
        wr0 = n_wr[0];
        pc_expect("g2_scan_miss", 3'd4, 3'd4, TIRO_FALLADO);
        poke(0, 3, 3, BARCO);
        @(negedge clk);
        clear_pokes();
        check("g2_back_to_player", 32'(shot_ready), 32'd1);
        check("g2_single_write",   32'(n_wr[0] - wr0), 32'd1);
        check("g2_pc_hits_miss",   32'(pc_hits), 32'd0);

        count_timeout(tmo);
        check("g2_timeout2_cycles", 32'(tmo), 32'(TT));
        pc_expect("g2_scan_hit", 3'd3, 3'd3, TIRO_ACERTADO);
        @(negedge clk);
        check("g2_pc_hits_hit",  32'(pc_hits), 32'd1);
        check("g2_hit_back",     32'(shot_ready), 32'd1);

        // Reset during PLAYER_EVAL must abort without writing the PC board.
        shot_valid = 1'b1; shot_row = 3'd1; shot_col = 3'd1;
        @(negedge clk);
        shot_valid = 1'b0;
        rst = 1'b1;
        #1 check("abort_no_write", 32'(wr_en), 32'd0);
        @(negedge clk);
        check("abort_outputs", 32'({shot_ready, player_turn, game_over, player_won,
                                    clear_req, repeat_shot, bad_coord, wr_en}), 32'd0);
        check("abort_hits", 32'({player_hits, pc_hits}), 32'd0);
        check("abort_board_untouched", 32'(board[1][1][1]), 32'(AGUA));
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'({shot_ready, player_turn}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
